data_mem_ctrl: RTL and testbench

Parametrised successor to the single-cycle data memory. Word-organised RAM with byte/half/word stores, sign/zero-extended loads, and a Req/Ready/Done handshake. Configurable wait-state latency; misaligned or out-of-range accesses are flagged. Sits between the multicycle CPU datapath (load/store stage) and on-chip data storage.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_load_fmt.sv | 25 ++
 rtl/data_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and the access-legality rule for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } dmem_state_t;

  // Alignment/size legality only; the range check depends on DEPTH and lives in the top.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return !lane[0];
      SZ_WORD: return lane == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed byte/half out of a RAM word and sign/zero extends it.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        Unsigned,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    value = word;
    if (size == SZ_BYTE)
      value = Unsigned ? {24'b0, b} : {{24{b[7]}}, b};
    else if (size == SZ_HALF)
      value = Unsigned ? {16'b0, h} : {{16{h[15]}}, h};
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM with Req/Ready/Done handshake, WAIT_CYCLES wait states and error flagging.
// RAM contents are not initialised; loads before the first store return X.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1,
  parameter string INIT_FILE = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic        Ready,
  output logic        Done,
  output logic        Err,
  output logic [31:0] Read_Data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        done_nxt, err_nxt;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] cur_word, merged, load_val;
  logic        legal;

  assign Ready    = (state == IDLE);
  assign legal    = is_legal(Size, Address[1:0]) && (Address[31:AW+2] == '0);
  assign cur_word = mem[addr_q[AW+1:2]];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          if (!legal) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACCESS: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      Read_Data <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Done  <= done_nxt;
      Err   <= err_nxt;
      if (state == ACCESS && !we_q) Read_Data <= load_val;
    end
  end

  // Request fields need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (Req && state == IDLE) begin
      we_q    <= WE;
      size_q  <= Size;
      uns_q   <= Unsigned;
      addr_q  <= Address[AW+1:0];
      wdata_q <= Write_Data;
    end
  end

  always_comb begin
    merged = cur_word;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Reset forces state to IDLE asynchronously, so an aborted store never reaches this write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !rst) mem[addr_q[AW+1:2]] <= merged;
  end

  dmem_load_fmt u_fmt (
    .word     (cur_word),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .Unsigned (uns_q),
    .value    (load_val)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: reference model feeds a scoreboard queue, compared when Done appears.
module tb_data_mem_ctrl;

  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        req0, we0, uns0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        ready0, done0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    bit          w;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m[int];
  logic [31:0] last_rd = 32'd0;

  data_mem_ctrl #(.DEPTH(128), .WAIT_CYCLES(W1)) u_dut (
    .clk(clk), .rst(rst), .Req(req), .WE(we), .Size(size), .Unsigned(uns),
    .Address(addr), .Write_Data(wdata), .Ready(ready), .Done(done), .Err(err),
    .Read_Data(rdata)
  );

  data_mem_ctrl #(.DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .Req(req0), .WE(we0), .Size(size0), .Unsigned(uns0),
    .Address(addr0), .Write_Data(wdata0), .Ready(ready0), .Done(done0), .Err(err0),
    .Read_Data(rdata0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input bit w, input logic [1:0] sz, input bit u,
                                input logic [31:0] a, input logic [31:0] d,
                                output bit e, output logic [31:0] rd);
    int nb, base, idx;
    logic [31:0] wd, v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a >= 32'd512);
    rd = last_rd;
    if (e) return;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[1:0]);
    idx  = int'(a >> 2);
    wd   = mem_m.exists(idx) ? mem_m[idx] : 32'hxxxxxxxx;
    if (w) begin
      for (int k = 0; k < nb; k++) wd[(base + k) * 8 +: 8] = d[k * 8 +: 8];
      mem_m[idx] = wd;
    end else begin
      v = 32'd0;
      for (int k = 0; k < nb; k++) v[k * 8 +: 8] = wd[(base + k) * 8 +: 8];
      if (!u && nb < 4 && v[nb * 8 - 1])
        for (int k = nb; k < 4; k++) v[k * 8 +: 8] = 8'hFF;
      last_rd = v;
      rd = v;
    end
  endfunction

  // Drives one request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input op_t op);
    exp_t e;
    req = 1'b1; we = op.w; size = op.sz; uns = op.u; addr = op.a; wdata = op.d;
    model(op.w, op.sz, op.u, op.a, op.d, e.err, e.rd);
    e.lat = e.err ? 0 : 1 + W1;
    @(negedge clk);
    e.acc = cyc;
    req = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int c, output bit to);
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      @(negedge clk);
    end
    to = !done;
    c  = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 0; we = 0; size = 0; uns = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, done, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset got rdy=%b done=%b err=%b rd=%h want 1 0 0 0", ready, done, err, rdata);
    end
    checks++;
    if ({ready0, done0, err0, rdata0} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_w0 got rdy=%b done=%b err=%b rd=%h want 1 0 0 0", ready0, done0, err0, rdata0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word;
    op_t ops [2] = '{'{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF},
                     '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0}};
    exp_t e; int c; bit to;
    foreach (ops[i]) begin
      issue(ops[i]);
      wait_done(c, to);
      e = exp_q.pop_front();
      checks++;
      if (to || (c - e.acc) != e.lat) begin failures++; $display("FAIL word[%0d] latency got=%0d want=%0d timeout=%0d", i, c - e.acc, e.lat, to); end
      checks++;
      if (err !== e.err) begin failures++; $display("FAIL word[%0d] err got=%b want=%b", i, err, e.err); end
      checks++;
      if (rdata !== e.rd) begin failures++; $display("FAIL word[%0d] rdata got=%h want=%h", i, rdata, e.rd); end
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_value got=%h want=deadbeef", rdata); end
  endtask

  task automatic test_byte_half;
    op_t ops [6] = '{'{1'b1, 2'd2, 1'b0, 32'h20, 32'h0},
                     '{1'b1, 2'd0, 1'b0, 32'h23, 32'h80},
                     '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0},
                     '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0},
                     '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0},
                     '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0}};
    exp_t e; int c; bit to;
    foreach (ops[i]) begin
      issue(ops[i]);
      wait_done(c, to);
      e = exp_q.pop_front();
      checks++;
      if (to || (c - e.acc) != e.lat) begin failures++; $display("FAIL bh[%0d] latency got=%0d want=%0d timeout=%0d", i, c - e.acc, e.lat, to); end
      checks++;
      if (err !== e.err) begin failures++; $display("FAIL bh[%0d] err got=%b want=%b", i, err, e.err); end
      checks++;
      if (rdata !== e.rd) begin failures++; $display("FAIL bh[%0d] rdata got=%h want=%h", i, rdata, e.rd); end
    end
    checks++;
    if (rdata !== 32'h80000000) begin failures++; $display("FAIL bh_word got=%h want=80000000", rdata); end
  endtask

  task automatic test_errors;
    op_t ops [8] = '{'{1'b0, 2'd2, 1'b0, 32'h12,  32'h0},
                     '{1'b0, 2'd1, 1'b0, 32'h21,  32'h0},
                     '{1'b0, 2'd3, 1'b0, 32'h20,  32'h0},
                     '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0},
                     '{1'b1, 2'd1, 1'b0, 32'h21,  32'hFFFF},
                     '{1'b1, 2'd0, 1'b0, 32'h1FF, 32'hC3},
                     '{1'b0, 2'd0, 1'b1, 32'h1FF, 32'h0},
                     '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0}};
    exp_t e; int c; bit to;
    foreach (ops[i]) begin
      issue(ops[i]);
      wait_done(c, to);
      e = exp_q.pop_front();
      checks++;
      if (to || (c - e.acc) != e.lat) begin failures++; $display("FAIL err[%0d] latency got=%0d want=%0d timeout=%0d", i, c - e.acc, e.lat, to); end
      checks++;
      if (err !== e.err) begin failures++; $display("FAIL err[%0d] err got=%b want=%b", i, err, e.err); end
      checks++;
      if (rdata !== e.rd) begin failures++; $display("FAIL err[%0d] rdata got=%h want=%h", i, rdata, e.rd); end
    end
  endtask

  task automatic test_ignored;
    op_t ld = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
    exp_t e; int c; bit to; int extra;
    issue(ld);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h0;
    @(negedge clk);
    req = 1'b0;
    wait_done(c, to);
    e = exp_q.pop_front();
    checks++;
    if (to || (c - e.acc) != e.lat) begin failures++; $display("FAIL ign latency got=%0d want=%0d timeout=%0d", c - e.acc, e.lat, to); end
    checks++;
    if (rdata !== e.rd) begin failures++; $display("FAIL ign rdata got=%h want=%h", rdata, e.rd); end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || !ready) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL ign_extra got=%0d busy/done cycles want=0", extra); end
    issue(ld);
    wait_done(c, to);
    e = exp_q.pop_front();
    checks++;
    if (to || rdata !== e.rd) begin failures++; $display("FAIL ign_mem got=%h want=%h timeout=%0d", rdata, e.rd, to); end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int dn = 0;
    bit pend = 0;
    int dq[$];
    int want;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; uns0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (ready0 !== !pend) begin failures++; $display("FAIL b2b ready[%0d] got=%b want=%b", i, ready0, !pend); end
      if (done0) begin
        dn++;
        want = (dq.size() > 0) ? dq.pop_front() : -1;
        checks++;
        if (cyc != want) begin failures++; $display("FAIL b2b done_cycle got=%0d want=%0d", cyc, want); end
      end
      pend = 0;
      if (ready0) begin
        if (acc < 4) begin
          req0 = 1'b1; addr0 = 32'(acc * 4); wdata0 = 32'hA5000000 + 32'(acc);
          dq.push_back(cyc + 2);
          acc++;
          pend = 1;
        end else begin
          req0 = 1'b0;
        end
      end
    end
    checks++;
    if (dn != 4 || dq.size() != 0) begin failures++; $display("FAIL b2b done_count got=%0d want=4 pending=%0d", dn, dq.size()); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    @(negedge clk);
    req0 = 1'b0;
    for (int k = 0; k < 10 && !done0; k++) @(negedge clk);
    checks++;
    if (!done0 || rdata0 !== 32'hA5000002) begin failures++; $display("FAIL b2b_load got=%h done=%b want=a5000002", rdata0, done0); end
  endtask

  task automatic test_reset_mid_store;
    op_t st0 = '{1'b1, 2'd2, 1'b0, 32'h40, 32'h0};
    op_t ld  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0};
    exp_t e; int c; bit to; int extra;
    issue(st0);
    wait_done(c, to);
    e = exp_q.pop_front();
    checks++;
    if (to || err !== 1'b0) begin failures++; $display("FAIL rst_pre got err=%b timeout=%0d want 0 0", err, to); end
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h40; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ready, done, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL rst_mid got rdy=%b done=%b err=%b rd=%h want 1 0 0 0", ready, done, err, rdata);
    end
    #1 rst = 1'b0;
    last_rd = 32'd0;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", extra); end
    issue(ld);
    wait_done(c, to);
    e = exp_q.pop_front();
    checks++;
    if (to || rdata !== e.rd) begin failures++; $display("FAIL rst_mem got=%h want=%h timeout=%0d", rdata, e.rd, to); end
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL rst_mem_value got=%h want=00000000", rdata); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_ignored();
    test_back_to_back();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
